// File: rtl/bu_mul_stage.sv
// Two-stage operand multiply ahead of the Barrett reducer: registers a/w, then
// forms the full 32-bit a*w while carrying the companion coefficient, tag and range flag.
`timescale 1ns/1ps

module bu_mul_stage #(
    parameter int Q     = 3329,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_w,
    input  logic [15:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_prod,
    output logic [15:0]      out_b,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [15:0]      prod_cnt
);

    localparam logic [15:0] Q_LIM = 16'(Q);

    typedef struct packed {
        logic [15:0]      a;
        logic [15:0]      w;
        logic [15:0]      b;
        logic [TAG_W-1:0] tag;
        logic             err;
    } s1_t;

    typedef struct packed {
        logic [31:0]      prod;
        logic [15:0]      b;
        logic [TAG_W-1:0] tag;
        logic             err;
    } s2_t;

    logic s1_v, s2_v;
    logic s1_adv, s2_adv;
    logic in_fire, out_fire;
    s1_t  s1_q, s1_d;
    s2_t  s2_q, s2_d;

    // Ready ripples back from the output so a full pipe can still take a new
    // item in the same cycle the oldest one leaves.
    always_comb begin
        s2_adv   = !s2_v || out_ready;
        s1_adv   = !s1_v || (s1_v && s2_adv);
        in_ready = s1_adv && !flush;
        in_fire  = in_valid && in_ready;
        out_fire = s2_v && out_ready;
    end

    always_comb begin
        s1_d.a    = in_a;
        s1_d.w    = in_w;
        s1_d.b    = in_b;
        s1_d.tag  = in_tag;
        s1_d.err  = (in_a >= Q_LIM) || (in_w >= Q_LIM);
        s2_d.prod = 32'(s1_q.a) * 32'(s1_q.w);
        s2_d.b    = s1_q.b;
        s2_d.tag  = s1_q.tag;
        s2_d.err  = s1_q.err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
            prod_cnt <= 16'd0;
        end else begin
            // A transfer handshaken during a flush cycle has already left.
            if (out_fire)
                prod_cnt <= prod_cnt + 16'd1;
            if (flush) begin
                s1_v <= 1'b0;
                s2_v <= 1'b0;
            end else begin
                if (s2_adv)
                    s2_v <= s1_v;
                if (s1_adv)
                    s1_v <= in_fire;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            if (in_fire)
                s1_q <= s1_d;
            if (s1_v && s2_adv && !flush)
                s2_q <= s2_d;
        end
    end

    assign out_valid = s2_v;
    assign out_prod  = s2_q.prod;
    assign out_b     = s2_q.b;
    assign out_tag   = s2_q.tag;
    assign out_err   = s2_q.err;

endmodule

// File: tb/tb_bu_mul_stage.sv
// Directed bench for bu_mul_stage: reset, single item, streaming, backpressure,
// range flag, flush, mid-flight reset and counter wrap.
`timescale 1ns/1ps

module tb_bu_mul_stage;

    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [15:0]      in_a, in_w, in_b, out_b, prod_cnt;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [31:0]      out_prod;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bu_mul_stage #(.Q(3329), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_w(in_w), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prod(out_prod), .out_b(out_b), .out_tag(out_tag),
        .out_err(out_err), .prod_cnt(prod_cnt)
    );

    // Leaves the bench at a falling edge with reset just released.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_w = '0; in_b = '0; in_tag = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++;
        if ({out_valid, out_err} !== 2'b00) begin
            fails++; $display("FAIL reset_flags: valid/err got %b want 00", {out_valid, out_err});
        end
        tests++;
        if ({out_prod, out_b, out_tag} !== '0) begin
            fails++; $display("FAIL reset_data: prod=%0d b=%0d tag=%0h want 0", out_prod, out_b, out_tag);
        end
        tests++;
        if (prod_cnt !== 16'd0) begin
            fails++; $display("FAIL reset_cnt: got %0d want 0", prod_cnt);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        in_a = 16'd1234; in_w = 16'd17; in_b = 16'd55; in_tag = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_prod !== 32'd20978 || out_b !== 16'd55 ||
            out_tag !== 8'h3C || out_err !== 1'b0) begin
            fails++;
            $display("FAIL single_out: v=%b prod=%0d b=%0d tag=%0h err=%b want 1/20978/55/3c/0",
                     out_valid, out_prod, out_b, out_tag, out_err);
        end
        @(negedge clk);
        tests++;
        if (prod_cnt !== 16'd1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL single_cnt: cnt=%0d v=%b want 1/0", prod_cnt, out_valid);
        end
    endtask

    task automatic test_stream();
        logic [15:0] sa [100];
        logic [15:0] sw [100];
        logic [31:0] exp_p;
        int sent, recv, drops;
        logic acc;
        for (int i = 0; i < 100; i++) begin
            sa[i] = 16'($urandom_range(3328, 0));
            sw[i] = 16'($urandom_range(3328, 0));
        end
        sa[37] = 16'd3328; sw[37] = 16'd3328;
        do_reset();
        sent = 0; recv = 0; drops = 0;
        for (int cyc = 0; cyc < 300 && recv < 100; cyc++) begin
            out_ready = 1'b1;
            in_valid  = (sent < 100);
            if (sent < 100) begin
                in_a = sa[sent]; in_w = sw[sent]; in_b = 16'(sent); in_tag = 8'(sent);
            end
            #1;
            if (in_valid && !in_ready) drops++;
            if (out_valid) begin
                exp_p = 32'(sa[recv]) * 32'(sw[recv]);
                tests++;
                if (out_prod !== exp_p || out_b !== 16'(recv) || out_tag !== 8'(recv) || out_err !== 1'b0) begin
                    fails++;
                    $display("FAIL stream_item%0d: prod=%0d b=%0d tag=%0d err=%b want %0d/%0d/%0d/0",
                             recv, out_prod, out_b, out_tag, out_err, exp_p, recv, recv & 255);
                end
                if (recv == 37) begin
                    tests++;
                    if (out_prod !== 32'd11075584) begin
                        fails++; $display("FAIL stream_max: got %0d want 11075584", out_prod);
                    end
                end
                recv++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        tests++;
        if (recv != 100) begin
            fails++; $display("FAIL stream_count: got %0d items want 100", recv);
        end
        tests++;
        if (drops != 0) begin
            fails++; $display("FAIL stream_in_ready: dropped %0d cycles want 0", drops);
        end
        tests++;
        if (prod_cnt !== 16'd100) begin
            fails++; $display("FAIL stream_cnt: got %0d want 100", prod_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] ba [4];
        logic [15:0] bw [4];
        logic [15:0] bb [4];
        logic [7:0]  bt [4];
        logic [31:0] bp [4];
        int sent, recv;
        logic acc;
        ba = '{16'd100, 16'd200, 16'd300, 16'd400};
        bw = '{16'd3, 16'd5, 16'd7, 16'd9};
        bb = '{16'd11, 16'd22, 16'd33, 16'd44};
        bt = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        bp = '{32'd300, 32'd1000, 32'd2100, 32'd3600};
        do_reset();
        sent = 0; recv = 0;
        for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
            out_ready = (cyc >= 5);
            in_valid  = (sent < 4);
            if (sent < 4) begin
                in_a = ba[sent]; in_w = bw[sent]; in_b = bb[sent]; in_tag = bt[sent];
            end
            #1;
            if (cyc == 4) begin
                tests++;
                if (sent != 2 || in_ready !== 1'b0) begin
                    fails++; $display("FAIL bp_accept: accepted=%0d in_ready=%b want 2/0", sent, in_ready);
                end
            end
            if (cyc >= 2 && cyc <= 4) begin
                tests++;
                if (out_valid !== 1'b1 || out_prod !== 32'd300 || out_b !== 16'd11 || out_tag !== 8'hA1) begin
                    fails++;
                    $display("FAIL bp_hold_c%0d: v=%b prod=%0d b=%0d tag=%0h want 1/300/11/a1",
                             cyc, out_valid, out_prod, out_b, out_tag);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (out_prod !== bp[recv] || out_b !== bb[recv] || out_tag !== bt[recv]) begin
                    fails++;
                    $display("FAIL bp_item%0d: prod=%0d b=%0d tag=%0h want %0d/%0d/%0h",
                             recv, out_prod, out_b, out_tag, bp[recv], bb[recv], bt[recv]);
                end
                recv++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        tests++;
        if (recv != 4 || prod_cnt !== 16'd4) begin
            fails++; $display("FAIL bp_total: items=%0d cnt=%0d want 4/4", recv, prod_cnt);
        end
    endtask

    task automatic test_error();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        in_a = 16'd3329; in_w = 16'd2; in_b = 16'd7; in_tag = 8'h01;
        @(negedge clk);
        in_a = 16'd3328; in_w = 16'd1; in_b = 16'd8; in_tag = 8'h02;
        @(negedge clk);
        in_a = 16'd5; in_w = 16'd3329; in_b = 16'd9; in_tag = 8'h03;
        tests++;
        if (out_valid !== 1'b1 || out_prod !== 32'd6658 || out_err !== 1'b1) begin
            fails++; $display("FAIL err_a_high: v=%b prod=%0d err=%b want 1/6658/1", out_valid, out_prod, out_err);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_prod !== 32'd3328 || out_err !== 1'b0) begin
            fails++; $display("FAIL err_legal_max: v=%b prod=%0d err=%b want 1/3328/0", out_valid, out_prod, out_err);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_prod !== 32'd16645 || out_err !== 1'b1 || out_tag !== 8'h03) begin
            fails++;
            $display("FAIL err_w_high: v=%b prod=%0d err=%b tag=%0h want 1/16645/1/03", out_valid, out_prod, out_err, out_tag);
        end
    endtask

    // Loads X then Y with the output blocked, leaving both stages occupied.
    task automatic fill_both();
        out_ready = 1'b0; in_valid = 1'b1;
        in_a = 16'd10; in_w = 16'd10; in_b = 16'd1; in_tag = 8'h10;
        @(negedge clk);
        in_a = 16'd20; in_w = 16'd20; in_b = 16'd2; in_tag = 8'h20;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        fill_both();
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || prod_cnt !== 16'd1) begin
            fails++; $display("FAIL flush_with_xfer: v=%b cnt=%0d want 0/1", out_valid, prod_cnt);
        end
        fill_both();
        flush = 1'b1; in_valid = 1'b1; in_a = 16'd99; in_w = 16'd99;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || prod_cnt !== 16'd1) begin
            fails++; $display("FAIL flush_drop: v=%b cnt=%0d want 0/1", out_valid, prod_cnt);
        end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || prod_cnt !== 16'd1) begin
            fails++; $display("FAIL flush_no_ghost: v=%b cnt=%0d want 0/1", out_valid, prod_cnt);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = 16'(i + 1); in_w = 16'd7; in_b = 16'(i); in_tag = 8'(i);
            @(negedge clk);
        end
        tests++;
        if (out_valid !== 1'b1 || prod_cnt !== 16'd1) begin
            fails++; $display("FAIL rst_pre: v=%b cnt=%0d want 1/1", out_valid, prod_cnt);
        end
        rst = 1'b1; flush = 1'b1; in_a = 16'd50;
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || prod_cnt !== 16'd0 || out_prod !== 32'd0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid: v=%b cnt=%0d prod=%0d rdy=%b want 0/0/0/1", out_valid, prod_cnt, out_prod, in_ready);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || prod_cnt !== 16'd0) begin
            fails++; $display("FAIL rst_no_ghost: v=%b cnt=%0d want 0/0", out_valid, prod_cnt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        in_a = 16'd2; in_w = 16'd3; in_b = 16'd0; in_tag = 8'h00;
        repeat (65535) @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (prod_cnt !== 16'hFFFF) begin
            fails++; $display("FAIL wrap_preload: got %0d want 65535", prod_cnt);
        end
        in_valid = 1'b1; in_a = 16'd9; in_w = 16'd9;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_prod !== 32'd81) begin
            fails++; $display("FAIL wrap_item: v=%b prod=%0d want 1/81", out_valid, out_prod);
        end
        @(negedge clk);
        tests++;
        if (prod_cnt !== 16'd0) begin
            fails++; $display("FAIL wrap_cnt: got %0d want 0", prod_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_w = '0; in_b = '0; in_tag = '0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_error();
        test_flush();
        test_rst_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
